byte_mem_loader: RTL

Sequencing controller directly upstream of the 4-byte memory system. It accepts a byte stream over a valid/ready handshake and writes each byte to the next address (0..3, wrapping), driving the memory's `data`/`store`/`addr` inputs with one-cycle store pulses and stable setup/hold. On request it dumps all four locations, in address order, through a valid/ready output port by reading the memory's `q`.

---
 rtl/byte_mem_loader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/byte_mem_loader.sv
// -----------------------------------------------------------------------------
// byte_mem_loader
//
// Sequencing controller in front of a 4-byte memory. Incoming bytes arrive on
// a valid/ready handshake. Each byte is written to the next address (0..3,
// wrapping) with a single-cycle store pulse. Address and data are held stable
// for HOLD_CYCLES cycles after the pulse. On dump_req the controller reads all
// four locations in address order and presents each one on a valid/ready
// output port.
//
// Parameters:
//   HOLD_CYCLES  cycles mem_addr/mem_data stay stable after the store pulse
//                (legal range 1..3)
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_data/in_valid      byte stream in
//   in_ready              byte accepted this cycle (combinational)
//   dump_req              request a read-out of addresses 0..3 (sampled in IDLE)
//   out_data/out_valid    read-back byte out
//   out_ready             consumer accepts out_data
//   dump_done             one-cycle pulse after the 4th read-back handshake
//   fill_count            bytes written since reset or last dump (saturates at 4)
//   mem_data/mem_store/mem_addr   memory write/address port
//   mem_q                 memory read data (combinational in mem_addr)
//
// Build option:
//   BYTE_MEM_LOADER_OVERWRITE_PROTECT_EN  when defined, writes are held off once
//   four bytes are stored and stay held off until a dump completes. Without
//   it, the fifth byte wraps around and overwrites address 0.
// -----------------------------------------------------------------------------
module byte_mem_loader #(
  parameter int HOLD_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       dump_req,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       dump_done,
  output logic [2:0] fill_count,
  output logic [7:0] mem_data,
  output logic       mem_store,
  output logic [1:0] mem_addr,
  input  logic [7:0] mem_q
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_STORE   = 3'd1;
  localparam logic [2:0] ST_HOLD    = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_OUT  = 3'd4;

  // The last value of the hold counter before HOLD exits.
  localparam logic [1:0] HOLD_LAST = 2'(HOLD_CYCLES - 1);

  logic [2:0] state_q,      state_d;
  logic [1:0] wr_ptr_q,     wr_ptr_d;
  logic [1:0] rd_ptr_q,     rd_ptr_d;
  logic [1:0] hold_cnt_q,   hold_cnt_d;
  logic [2:0] fill_count_q, fill_count_d;
  logic       mem_store_q,  mem_store_d;
  logic [1:0] mem_addr_q,   mem_addr_d;
  logic [7:0] mem_data_q,   mem_data_d;
  logic [7:0] out_data_q,   out_data_d;
  logic       out_valid_q,  out_valid_d;
  logic       dump_done_q,  dump_done_d;
  logic       full;

`ifdef BYTE_MEM_LOADER_OVERWRITE_PROTECT_EN
  assign full = (fill_count_q == 3'd4);
`else
  assign full = 1'b0;
`endif

  // Dump requests take priority, so a pending dump_req masks in_ready. The
  // rst_n term keeps in_ready low for the whole time reset is asserted.
  assign in_ready = rst_n & (state_q == ST_IDLE) & ~dump_req & ~full;

  always_comb begin
    // NOTE: every signal gets a default here first, so no path can leave a
    // value unassigned. That prevents latch inference.
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    hold_cnt_d   = hold_cnt_q;
    fill_count_d = fill_count_q;
    mem_store_d  = mem_store_q;
    mem_addr_d   = mem_addr_q;
    mem_data_d   = mem_data_q;
    out_data_d   = out_data_q;
    out_valid_d  = out_valid_q;
    dump_done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (dump_req) begin
          state_d     = ST_RD_ADDR;
          rd_ptr_d    = 2'd0;
          mem_addr_d  = 2'd0;
          mem_store_d = 1'b0;
        end else if (in_valid && in_ready) begin
          state_d     = ST_STORE;
          mem_data_d  = in_data;
          mem_addr_d  = wr_ptr_q;
          mem_store_d = 1'b1;
        end
      end

      ST_STORE: begin
        state_d     = ST_HOLD;
        mem_store_d = 1'b0;
        hold_cnt_d  = 2'd0;
      end

      // mem_addr/mem_data are deliberately left alone here, so the memory
      // sees a stable address and data after the store pulse.
      ST_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          state_d  = ST_IDLE;
          wr_ptr_d = wr_ptr_q + 2'd1;
          if (fill_count_q != 3'd4) begin
            fill_count_d = fill_count_q + 3'd1;
          end
        end else begin
          hold_cnt_d = hold_cnt_q + 2'd1;
        end
      end

      // mem_addr already points at rd_ptr. mem_q is settled by the end of
      // this cycle.
      ST_RD_ADDR: begin
        state_d     = ST_RD_OUT;
        mem_store_d = 1'b0;
        out_data_d  = mem_q;
        out_valid_d = 1'b1;
      end

      ST_RD_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (rd_ptr_q == 2'd3) begin
            state_d      = ST_IDLE;
            dump_done_d  = 1'b1;
            fill_count_d = 3'd0;
          end else begin
            state_d    = ST_RD_ADDR;
            rd_ptr_d   = rd_ptr_q + 2'd1;
            mem_addr_d = rd_ptr_q + 2'd1;
          end
        end
      end

      default: begin
        state_d     = ST_IDLE;
        mem_store_d = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state flops use non-blocking assignments only, so every flop
  // samples its value from before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= 2'd0;
      rd_ptr_q     <= 2'd0;
      hold_cnt_q   <= 2'd0;
      fill_count_q <= 3'd0;
      mem_store_q  <= 1'b0;
      mem_addr_q   <= 2'd0;
      mem_data_q   <= 8'd0;
      out_data_q   <= 8'd0;
      out_valid_q  <= 1'b0;
      dump_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      hold_cnt_q   <= hold_cnt_d;
      fill_count_q <= fill_count_d;
      mem_store_q  <= mem_store_d;
      mem_addr_q   <= mem_addr_d;
      mem_data_q   <= mem_data_d;
      out_data_q   <= out_data_d;
      out_valid_q  <= out_valid_d;
      dump_done_q  <= dump_done_d;
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign dump_done  = dump_done_q;
  assign fill_count = fill_count_q;
  assign mem_data   = mem_data_q;
  assign mem_store  = mem_store_q;
  assign mem_addr   = mem_addr_q;

endmodule
